// File: rtl/dac_mon_pkg.sv
// dac_mon_pkg: shared state encoding and frame field layout for dac_frame_monitor.
package dac_mon_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HIGH} state_t;
  localparam int FRAME_BITS = 16;
  localparam int PD_MSB = 15;
  localparam int PD_LSB = 14;
  localparam int CODE_MSB = 13;
  localparam int CODE_LSB = 2;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
endpackage

// File: rtl/dac_line_sync.sv
// dac_line_sync: N-stage synchronizer with registered rise/fall detect.
// Edges are blanked until the chain has flushed after reset, so a pin already away from RST_VAL is not seen as an edge.
module dac_line_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic [STAGES:0] vld;
  logic en;
  assign en = &vld;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= {STAGES{RST_VAL}};
      vld <= '0;
      q <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      vld <= {vld[STAGES-1:0], 1'b1};
      q <= s[STAGES-1];
      rise <= en & ~q & s[STAGES-1];
      fall <= en & q & ~s[STAGES-1];
    end
  end
endmodule

// File: rtl/dac_frame_monitor.sv
// dac_frame_monitor: oversampling decoder of the DAC sck/sdi/sync_n write frames.
// Optional DAC_MON_TIMEOUT_EN aborts a frame whose sck stalls for TIMEOUT_CYC cycles.
module dac_frame_monitor
  import dac_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        Dac_sck,
  input  logic        Dac_sdi,
  input  logic        Dac_sync_n,
  output logic        frame_valid,
  output logic [11:0] dac_code,
  output logic [1:0]  pd_mode,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);
  logic sck_q, sck_rise, sck_fall, sdi_q, sdi_rise, sdi_fall, sync_q, sync_rise, sync_fall;
  logic unused_ok;
  state_t state, state_n;
  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [4:0] bit_cnt, cnt_n;
  logic accept, abort;

  dac_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk50), .rst(rst), .d(Dac_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  dac_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk50), .rst(rst), .d(Dac_sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));
  dac_line_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk50), .rst(rst), .d(Dac_sync_n), .q(sync_q), .rise(sync_rise), .fall(sync_fall));

  assign unused_ok = &{sck_q, sck_rise, sdi_rise, sdi_fall, sync_q};
  assign busy = state != IDLE;

`ifdef DAC_MON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic stalled;
  assign stalled = tcnt == TW'(TIMEOUT_CYC);
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) tcnt <= '0;
    else tcnt <= (state != SHIFT || sck_fall) ? '0 : stalled ? tcnt : tcnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYC;
`endif

  // A 16th bit arriving with the sync_n rise is judged on the updated count.
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = bit_cnt;
    accept = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: if (sync_fall) begin
        sr_n = '0;
        cnt_n = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (sck_fall) begin
          sr_n = {sr[FRAME_BITS-2:0], sdi_q};
          cnt_n = bit_cnt + 5'd1;
        end
        if (cnt_n == 5'(FRAME_BITS)) begin
          accept = 1'b1;
          state_n = sync_rise ? IDLE : WAIT_HIGH;
        end else if (sync_rise) begin
          abort = 1'b1;
          state_n = IDLE;
        end
`ifdef DAC_MON_TIMEOUT_EN
        else if (!sck_fall && stalled) begin
          abort = 1'b1;
          state_n = WAIT_HIGH;
        end
`endif
      end
      WAIT_HIGH: if (sync_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      dac_code <= '0;
      pd_mode <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      bit_cnt <= cnt_n;
      frame_valid <= accept;
      frame_err <= abort;
      if (accept) begin
        dac_code <= sr_n[CODE_MSB:CODE_LSB];
        pd_mode <= sr_n[PD_MSB:PD_LSB];
      end
      if (abort && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: doc/dac_frame_monitor.md
# dac_frame_monitor

Serial responder for the three-wire DAC write interface (sck/sdi/sync_n) used by the threshold and MCP HVPS DACs. Taps the DAC lines in parallel with the physical DAC and decodes each 16-bit frame exactly as the DAC does. It presents the last accepted 12-bit code and power-down bits for housekeeping readback and HV-command cross-check. It counts malformed frames. Runs entirely in the clk50 domain by oversampling the DAC lines.

## Interface
- FRAME_BITS, 16, bits per DAC frame: PD1 PD0 D11..D0 X X, MSB first
- SYNC_STAGES, 2, synchronizer flops on each DAC input (min 2)
- TIMEOUT_CYC, 4096, clk50 cycles without an sck falling edge before a frame aborts (used only with the timeout macro)
- clk50  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- Dac_sck  in  1  DAC serial clock, asynchronous to clk50
- Dac_sdi  in  1  DAC serial data
- Dac_sync_n  in  1  DAC frame sync, active low
- frame_valid  out  1  one-cycle pulse when a frame is accepted
- dac_code  out  12  last accepted D11..D0, held between frames
- pd_mode  out  2  last accepted PD1..PD0, held
- frame_err  out  1  one-cycle pulse on abort
- err_cnt  out  8  aborted-frame count, saturating
- busy  out  1  high in SHIFT or WAIT_HIGH

## Operation
- All three inputs pass through SYNC_STAGES flops. Reset values: sck 0, sdi 0, sync_n 1.
- Falling-edge detect on synchronized sck and sync_n. Rising-edge detect on sync_n.
- sdi is sampled from its synchronized copy in the cycle in which the sck fall is detected.
- FSM states: IDLE, SHIFT, WAIT_HIGH.
- IDLE: on sync_n fall, clear shift register and bit_cnt, then go to SHIFT. sck edges are ignored.
- SHIFT: each sck fall shifts sdi into the LSB and increments bit_cnt.
  - When bit_cnt reaches FRAME_BITS: load dac_code = sr[13:2] and pd_mode = sr[15:14], pulse frame_valid, go to WAIT_HIGH.
  - sync_n rise with bit_cnt < FRAME_BITS is an abort: frame_err pulse, err_cnt +1 (holds at 255), dac_code and pd_mode unchanged, go to IDLE.
- WAIT_HIGH: further sck falls are ignored. sync_n rise returns to IDLE.
- Simultaneous sck fall and sync_n rise in one cycle: the bit is counted first, then the rise is evaluated against the updated count. A 16th bit and the rise together give a valid frame and a return to IDLE.
- sync_n fall while in WAIT_HIGH is impossible without a prior rise, so it needs no handling.
- Reset values: frame_valid 0, frame_err 0, busy 0, dac_code 0x000, pd_mode 0, err_cnt 0, state IDLE.
- Reset mid-frame discards the partial frame and does not count an error.
- sync_n held low at reset release yields no frame; the next sync_n fall is required.

## Timing
- Input latency is SYNC_STAGES+1 cycles from a pin edge to its detect.
- frame_valid and dac_code/pd_mode update in the cycle after the 16th sck fall is detected, i.e. SYNC_STAGES+2 clk50 cycles after the pin edge.
- dac_code and pd_mode change in the same cycle frame_valid is high.
- Input requirements:
  - sck high and low phases each at least 3 clk50 cycles.
  - sdi stable at least 2 cycles before and after each sck fall.
  - sync_n high at least 3 cycles between frames.
- frame_err and the err_cnt update land one cycle after the sync_n rise is detected.

## Configuration
- DAC_MON_TIMEOUT_EN defined: a counter runs in SHIFT, clears on each sck fall, and saturates at TIMEOUT_CYC. Reaching TIMEOUT_CYC aborts the frame (frame_err, err_cnt +1, go to WAIT_HIGH so the stuck frame is not re-armed until sync_n rises).
- DAC_MON_TIMEOUT_EN undefined: SHIFT waits indefinitely. TIMEOUT_CYC is unused and no counter is synthesized.

## Structure
- Package dac_mon_pkg holds the state enum, FRAME_BITS, the field positions PD_MSB=15, PD_LSB=14, CODE_MSB=13, CODE_LSB=2, and the ERR_CNT_MAX=8'hFF constant.
- One sub-module, dac_line_sync: an N-stage synchronizer with a parameterized reset value and rise/fall detect outputs. It is instantiated once per input.
- The FSM, shift register, counters and output registers stay in the top.

## Test plan
- Send frame 0x26C4 with sck period 8 cycles → one frame_valid pulse, dac_code 0x9B1, pd_mode 0, err_cnt 0.
- Send frame 0xC040 then 0x0028 back to back → two frame_valid pulses; final dac_code 0x00A, pd_mode 0. After the first frame, pd_mode is 3 and dac_code is 0x010.
- Raise sync_n after 9 sck falls → frame_err pulse, err_cnt 1, dac_code still holds its prior value.
- Send 20 sck falls in one sync_n window → one frame_valid on the 16th bit, bits 17–20 ignored, no error.
- With DAC_MON_TIMEOUT_EN defined, stall sck low for 4096 cycles mid-frame → frame_err and busy until sync_n rises. Without the macro, the same stimulus gives no error, and the frame completes when sck resumes.
- Assert rst mid-frame, and separately issue 260 aborts → after reset all outputs are 0 and the next frame decodes correctly; err_cnt stops at 255.
